acc_alu: RTL and testbench

ACC_ALU -- requirements
Module: acc_alu

---
 rtl/acc_alu.sv | 230 +++++++++++++++++++++++
 tb/tb_acc_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - accumulator ALU with single-cycle logic/arith ops, serial shifts and optional serial multiply
//
// Purpose: executes one opcode per accepted start against a registered accumulator.
//          Add/sub/logic/load ops finish in one edge. Shifts by k>=1 step one bit per edge.
//          Multiply (when built in) does one shift-add partial product per edge.
// Build option: define ACC_ALU_MUL_EN to include opcode 0011 (MUL) and its registers;
//               without it 0011 is a NOP.
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high
//   start    - execute alu_ctrl on rd_data (ignored while busy)
//   alu_ctrl - 4-bit opcode, sampled with start
//   rd_data  - operand, or shift amount in the low log2(WIDTH) bits
//   acc_out  - registered accumulator
//   carry    - registered carry/borrow flag
//   zero     - registered, 1 when acc_out == 0
//   busy     - multi-cycle operation in progress (state != IDLE)
//   done     - one-cycle pulse after each accepted operation completes
module acc_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int SW = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for the multiply
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ASR  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_ADC  = 4'b1010;
    localparam logic [3:0] OP_SBB  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_LOAD = 4'b1111;

    // Low two opcode bits select the shift flavour
    localparam logic [1:0] SH_SHL = 2'b00;
    localparam logic [1:0] SH_SHR = 2'b01;
    localparam logic [1:0] SH_ROL = 2'b10;

`ifdef ACC_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] acc_n;
    logic             carry_n;
    logic             done_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [1:0]       sop, sop_n;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] sh_acc;
    logic             sh_c;
    logic [SW-1:0]    amt;

`ifdef ACC_ALU_MUL_EN
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH:0]     psum;
`endif

    assign amt  = rd_data[SW-1:0];
    assign busy = (state != IDLE);

    // One step of the latched shift flavour applied to the current accumulator
    always_comb begin
        sh_acc = acc_out;
        sh_c   = carry;
        case (sop)
            SH_SHL: begin
                sh_c   = acc_out[WIDTH-1];
                sh_acc = {acc_out[WIDTH-2:0], 1'b0};
            end
            SH_SHR: begin
                sh_c   = acc_out[0];
                sh_acc = {1'b0, acc_out[WIDTH-1:1]};
            end
            SH_ROL: begin
                // Carry mirrors the bit that wraps into bit 0
                sh_c   = acc_out[WIDTH-1];
                sh_acc = {acc_out[WIDTH-2:0], acc_out[WIDTH-1]};
            end
            default: begin
                sh_c   = acc_out[0];
                sh_acc = {acc_out[WIDTH-1], acc_out[WIDTH-1:1]};
            end
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc_out;
        carry_n = carry;
        cnt_n   = cnt;
        sop_n   = sop;
        done_n  = 1'b0;
        ext     = '0;
`ifdef ACC_ALU_MUL_EN
        mcand_n = mcand;
        prod_n  = prod;
        psum    = '0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    // Single-cycle by default; multi-cycle ops withdraw done below
                    done_n = 1'b1;
                    case (alu_ctrl)
                        OP_ADD: begin
                            ext     = {1'b0, acc_out} + {1'b0, rd_data};
                            acc_n   = ext[WIDTH-1:0];
                            carry_n = ext[WIDTH];
                        end
                        OP_ADC: begin
                            ext     = {1'b0, acc_out} + {1'b0, rd_data} + {{WIDTH{1'b0}}, carry};
                            acc_n   = ext[WIDTH-1:0];
                            carry_n = ext[WIDTH];
                        end
                        OP_SUB: begin
                            // Top bit of the widened difference is the unsigned borrow
                            ext     = {1'b0, acc_out} - {1'b0, rd_data};
                            acc_n   = ext[WIDTH-1:0];
                            carry_n = ext[WIDTH];
                        end
                        OP_SBB: begin
                            ext     = {1'b0, acc_out} - {1'b0, rd_data} - {{WIDTH{1'b0}}, carry};
                            acc_n   = ext[WIDTH-1:0];
                            carry_n = ext[WIDTH];
                        end
                        OP_AND:  acc_n = acc_out & rd_data;
                        OP_OR:   acc_n = acc_out | rd_data;
                        OP_XOR:  acc_n = acc_out ^ rd_data;
                        OP_LOAD: acc_n = rd_data;
                        OP_SHL, OP_SHR, OP_ROL, OP_ASR: begin
                            // Zero-length shifts finish here with nothing changed
                            if (amt != '0) begin
                                state_n = SHIFT;
                                cnt_n   = {1'b0, amt};
                                sop_n   = alu_ctrl[1:0];
                                done_n  = 1'b0;
                            end
                        end
`ifdef ACC_ALU_MUL_EN
                        OP_MUL: begin
                            state_n = MUL;
                            cnt_n   = CW'(WIDTH);
                            mcand_n = acc_out;
                            prod_n  = {{WIDTH{1'b0}}, rd_data};
                            done_n  = 1'b0;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                acc_n   = sh_acc;
                carry_n = sh_c;
                cnt_n   = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
`ifdef ACC_ALU_MUL_EN
            MUL: begin
                // Right-shifting shift-add: the multiplier drains out of the low half
                // while the product accumulates in the high half.
                psum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
                prod_n = {psum, prod[WIDTH-1:1]};
                cnt_n  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    acc_n   = prod_n[WIDTH-1:0];
                    carry_n = |prod_n[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc_out <= '0;
            carry   <= 1'b0;
            zero    <= 1'b1;
            done    <= 1'b0;
            cnt     <= '0;
            sop     <= '0;
`ifdef ACC_ALU_MUL_EN
            mcand   <= '0;
            prod    <= '0;
`endif
        end else begin
            state   <= state_n;
            acc_out <= acc_n;
            carry   <= carry_n;
            zero    <= (acc_n == '0);
            done    <= done_n;
            cnt     <= cnt_n;
            sop     <= sop_n;
`ifdef ACC_ALU_MUL_EN
            mcand   <= mcand_n;
            prod    <= prod_n;
`endif
        end
    end

endmodule

// File: tb/tb_acc_alu.sv
// tb/tb_acc_alu.sv - directed self-checking bench for acc_alu (WIDTH=8)
module tb_acc_alu;

    localparam int WIDTH = 8;

    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ASR  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_ADC  = 4'b1010;
    localparam logic [3:0] OP_SBB  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_LOAD = 4'b1111;

    logic             clk;
    logic             reset;
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] acc_out;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    int n_assert;
    int n_fail;

    acc_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .rd_data  (rd_data),
        .acc_out  (acc_out),
        .carry    (carry),
        .zero     (zero),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one start for one edge; returns at the negedge after the accepting edge
    task automatic op(input logic [3:0] c, input logic [7:0] d);
        start    = 1'b1;
        alu_ctrl = c;
        rd_data  = d;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b1;
        alu_ctrl = OP_LOAD;
        rd_data  = 8'h55;

        // Reset with a concurrent start: start must be discarded
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc",   acc_out, 8'h00);
        chk("rst_carry", carry,   1'b0);
        chk("rst_zero",  zero,    1'b1);
        chk("rst_busy",  busy,    1'b0);
        chk("rst_done",  done,    1'b0);
        reset = 1'b0;
        start = 1'b0;
        idle_cycle();
        chk("post_rst_acc",  acc_out, 8'h00);
        chk("post_rst_done", done,    1'b0);

        // LOAD F0, ADD 20
        op(OP_LOAD, 8'hF0);
        chk("load_acc",  acc_out, 8'hF0);
        chk("load_done", done,    1'b1);
        chk("load_busy", busy,    1'b0);
        chk("load_zero", zero,    1'b0);
        op(OP_ADD, 8'h20);
        chk("add_acc",   acc_out, 8'h10);
        chk("add_carry", carry,   1'b1);
        chk("add_zero",  zero,    1'b0);
        chk("add_done",  done,    1'b1);
        chk("add_busy",  busy,    1'b0);
        idle_cycle();
        chk("done_pulse_end", done, 1'b0);

        // LOAD 05, SUB 06, SBB 00
        op(OP_LOAD, 8'h05);
        op(OP_SUB, 8'h06);
        chk("sub_acc",   acc_out, 8'hFF);
        chk("sub_carry", carry,   1'b1);
        op(OP_SBB, 8'h00);
        chk("sbb_acc",   acc_out, 8'hFE);
        chk("sbb_carry", carry,   1'b0);

        // ADD wrap to zero, then ADC consumes the carry
        op(OP_LOAD, 8'hFF);
        op(OP_ADD, 8'h01);
        chk("wrap_acc",   acc_out, 8'h00);
        chk("wrap_carry", carry,   1'b1);
        chk("wrap_zero",  zero,    1'b1);
        op(OP_ADC, 8'h05);
        chk("adc_acc",   acc_out, 8'h06);
        chk("adc_carry", carry,   1'b0);

        // Logic ops keep carry
        op(OP_LOAD, 8'h3C);
        op(OP_AND, 8'h0F);
        chk("and_acc", acc_out, 8'h0C);
        op(OP_XOR, 8'hFF);
        chk("xor_acc",   acc_out, 8'hF3);
        chk("xor_carry", carry,   1'b0);

        // NOP 0000 leaves state unchanged but pulses done
        op(4'b0000, 8'hAA);
        chk("nop_acc",  acc_out, 8'hF3);
        chk("nop_done", done,    1'b1);

        // LOAD 81, ASR 3 with start pulses while busy
        op(OP_LOAD, 8'h81);
        op(OP_ASR, 8'h03);
        chk("asr_busy0", busy, 1'b1);
        chk("asr_done0", done, 1'b0);
        start    = 1'b1;
        alu_ctrl = OP_LOAD;
        rd_data  = 8'h00;
        @(negedge clk);
        chk("asr_acc1",  acc_out, 8'hC0);
        chk("asr_busy1", busy,    1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("asr_acc2",  acc_out, 8'hE0);
        chk("asr_busy2", busy,    1'b1);
        @(negedge clk);
        chk("asr_acc",   acc_out, 8'hF0);
        chk("asr_carry", carry,   1'b0);
        chk("asr_busy",  busy,    1'b0);
        chk("asr_done",  done,    1'b1);

        // LOAD 81, ROL 1, then SHL 0
        op(OP_LOAD, 8'h81);
        op(OP_ROL, 8'h01);
        chk("rol_busy0", busy, 1'b1);
        @(negedge clk);
        chk("rol_acc",   acc_out, 8'h03);
        chk("rol_carry", carry,   1'b1);
        chk("rol_done",  done,    1'b1);
        op(OP_SHL, 8'h00);
        chk("shl0_acc",   acc_out, 8'h03);
        chk("shl0_carry", carry,   1'b1);
        chk("shl0_busy",  busy,    1'b0);
        chk("shl0_done",  done,    1'b1);

        // Clear carry, then LOAD 10, MUL 20
        op(OP_LOAD, 8'h00);
        op(OP_ADD, 8'h00);
        chk("clr_carry", carry, 1'b0);
        op(OP_LOAD, 8'h10);
        op(OP_MUL, 8'h20);
`ifdef ACC_ALU_MUL_EN
        for (int i = 0; i < 7; i++) begin
            chk("mul_busy", busy, 1'b1);
            chk("mul_done", done, 1'b0);
            @(negedge clk);
        end
        chk("mul_last_busy", busy, 1'b1);
        @(negedge clk);
        chk("mul_acc",   acc_out, 8'h00);
        chk("mul_carry", carry,   1'b1);
        chk("mul_zero",  zero,    1'b1);
        chk("mul_busy_end", busy, 1'b0);
        chk("mul_done_end", done, 1'b1);
`else
        chk("nomul_acc",   acc_out, 8'h10);
        chk("nomul_carry", carry,   1'b0);
        chk("nomul_zero",  zero,    1'b0);
        chk("nomul_busy",  busy,    1'b0);
        chk("nomul_done",  done,    1'b1);
`endif

        // Reset in the middle of SHR 7
        op(OP_LOAD, 8'hFF);
        op(OP_SHR, 8'h07);
        chk("shr_busy0", busy, 1'b1);
        @(negedge clk);
        chk("shr_acc1", acc_out, 8'h7F);
        @(negedge clk);
        chk("shr_acc2", acc_out, 8'h3F);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_acc",  acc_out, 8'h00);
        chk("abort_busy", busy,    1'b0);
        chk("abort_done", done,    1'b0);
        chk("abort_zero", zero,    1'b1);
        idle_cycle();
        chk("abort_no_done", done, 1'b0);
        op(OP_LOAD, 8'h42);
        chk("after_abort_acc",  acc_out, 8'h42);
        chk("after_abort_done", done,    1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
